// File: rtl/fibo_stream_checker.sv
// -----------------------------------------------------------------------------
// fibo_stream_checker
//
// Receive-side checker for a Fibonacci word stream. The first two accepted
// words become the seeds (a, b); every later word must equal (a + b) modulo
// 2^WIDTH. A matching word shifts the pair forward; a mismatching word raises a
// one-cycle err pulse, spends one RESYNC cycle with in_ready low, and then
// becomes the first seed of a fresh lock.
//
// Optional feature macro: FIBO_STREAM_CHECKER_STRICT_SEED_EN
//   When defined, the seeds must be the generator's reset pair (0, 1), and a
//   mismatch always restarts from SEED0 with a cleared.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-high reset
//   in_valid     in   a word is offered on in_data
//   in_data      in   stream word (WIDTH bits)
//   in_ready     out  checker accepts a word this cycle (combinational)
//   clear        in   synchronous restart to SEED0, counters zeroed
//   locked       out  checker is in TRACK state (registered)
//   err          out  one-cycle pulse after a rejected word (registered)
//   expected     out  next expected word while locked, else 0 (combinational)
//   match_count  out  saturating count of matching words (registered)
//   err_count    out  saturating count of mismatches (registered)
// -----------------------------------------------------------------------------
module fibo_stream_checker #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             clear,
    output logic             locked,
    output logic             err,
    output logic [WIDTH-1:0] expected,
    output logic [CNT_W-1:0] match_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        ST_SEED0  = 2'd0,
        ST_SEED1  = 2'd1,
        ST_TRACK  = 2'd2,
        ST_RESYNC = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] mcnt_q, mcnt_d;
    logic [CNT_W-1:0] ecnt_q, ecnt_d;

    logic             in_ready_s;
    logic             accept_s;
    logic [WIDTH-1:0] sum_s;
    logic             match_s;

    // Saturating increment: a counter at all-ones holds its value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    // Handshake and recurrence datapath; the sum truncates to WIDTH bits.
    always_comb begin
        in_ready_s = (state_q != ST_RESYNC) && !clear;
        accept_s   = in_valid && in_ready_s;
        sum_s      = a_q + b_q;
        match_s    = (in_data == sum_s);
    end

    // Next-state logic for the seed/track/resync sequence and counters.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        err_d   = 1'b0;
        mcnt_d  = mcnt_q;
        ecnt_d  = ecnt_q;

        if (clear) begin
            // clear wins over any offered word; in_ready is low so nothing is consumed
            state_d = ST_SEED0;
            a_d     = {WIDTH{1'b0}};
            b_d     = {WIDTH{1'b0}};
            mcnt_d  = {CNT_W{1'b0}};
            ecnt_d  = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                ST_SEED0: begin
                    if (accept_s) begin
`ifdef FIBO_STREAM_CHECKER_STRICT_SEED_EN
                        if (in_data != {WIDTH{1'b0}}) begin
                            err_d  = 1'b1;
                            ecnt_d = sat_inc(ecnt_q);
                        end else begin
                            a_d     = in_data;
                            state_d = ST_SEED1;
                        end
`else
                        a_d     = in_data;
                        state_d = ST_SEED1;
`endif
                    end else begin
                        state_d = ST_SEED0;
                    end
                end
                ST_SEED1: begin
                    if (accept_s) begin
`ifdef FIBO_STREAM_CHECKER_STRICT_SEED_EN
                        if (in_data != WIDTH'(1)) begin
                            err_d   = 1'b1;
                            ecnt_d  = sat_inc(ecnt_q);
                            state_d = ST_SEED0;
                        end else begin
                            b_d     = in_data;
                            state_d = ST_TRACK;
                        end
`else
                        b_d     = in_data;
                        state_d = ST_TRACK;
`endif
                    end else begin
                        state_d = ST_SEED1;
                    end
                end
                ST_TRACK: begin
                    if (accept_s) begin
                        if (match_s) begin
                            a_d    = b_q;
                            b_d    = in_data;
                            mcnt_d = sat_inc(mcnt_q);
                        end else begin
                            // the rejected word becomes the first seed of the next lock
                            err_d   = 1'b1;
                            ecnt_d  = sat_inc(ecnt_q);
                            a_d     = in_data;
                            state_d = ST_RESYNC;
                        end
                    end else begin
                        state_d = ST_TRACK;
                    end
                end
                ST_RESYNC: begin
`ifdef FIBO_STREAM_CHECKER_STRICT_SEED_EN
                    a_d     = {WIDTH{1'b0}};
                    state_d = ST_SEED0;
`else
                    state_d = ST_SEED1;
`endif
                end
                default: begin
                    state_d = ST_SEED0;
                    a_d     = {WIDTH{1'b0}};
                    b_d     = {WIDTH{1'b0}};
                end
            endcase
        end

        // locked is registered, so it follows the state we are about to enter
        locked_d = (state_d == ST_TRACK);
    end

    // State, seed pair, status flags and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_SEED0;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            mcnt_q   <= {CNT_W{1'b0}};
            ecnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            mcnt_q   <= mcnt_d;
            ecnt_q   <= ecnt_d;
        end
    end

    assign in_ready    = in_ready_s;
    assign locked      = locked_q;
    assign err         = err_q;
    assign expected    = (state_q == ST_TRACK) ? sum_s : {WIDTH{1'b0}};
    assign match_count = mcnt_q;
    assign err_count   = ecnt_q;

endmodule

// File: tb/tb_fibo_stream_checker.sv
// -----------------------------------------------------------------------------
// Self-checking bench for fibo_stream_checker. Expected outputs after each
// accepted word come from hand-written tables or a small bench-side loop and
// are queued when the word is driven, then popped and compared after the edge.
// A small counter width is used so that saturation is reachable quickly.
// -----------------------------------------------------------------------------
module tb_fibo_stream_checker;

    localparam int W  = 8;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          clear;
    logic          locked;
    logic          err;
    logic [W-1:0]  expected;
    logic [CW-1:0] match_count;
    logic [CW-1:0] err_count;

    fibo_stream_checker #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .clear       (clear),
        .locked      (locked),
        .err         (err),
        .expected    (expected),
        .match_count (match_count),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  din;
        logic        lk;
        logic        er;
        logic [7:0]  ex;
        logic [15:0] mc;
        logic [15:0] ec;
    } vec_t;

    vec_t exp_q[$];
    vec_t fib_tab[8];
    vec_t wrap_tab[4];
    vec_t mis_tab[7];

    int checks   = 0;
    int failures = 0;

    function automatic vec_t mk(input logic [7:0] d, input logic lk, input logic er,
                                input logic [7:0] ex, input int mc, input int ec);
        vec_t v;
        v.din = d; v.lk = lk; v.er = er; v.ex = ex;
        v.mc = 16'(mc); v.ec = 16'(ec);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Offer one word after 'gap' idle cycles, wait (bounded) for in_ready,
    // then compare all registered/combinational outputs after the accept edge.
    task automatic send(input vec_t e, input int gap, input string nm);
        vec_t g;
        int   n;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = e.din;
        #1;
        n = 0;
        while (!in_ready && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({nm, " in_ready"}, {31'd0, in_ready}, 32'd1);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        g = exp_q.pop_front();
        chk({nm, " locked"},      {31'd0, locked},      {31'd0, g.lk});
        chk({nm, " err"},         {31'd0, err},         {31'd0, g.er});
        chk({nm, " expected"},    {24'd0, expected},    {24'd0, g.ex});
        chk({nm, " match_count"}, {29'd0, match_count}, {16'd0, g.mc});
        chk({nm, " err_count"},   {29'd0, err_count},   {16'd0, g.ec});
    endtask

    task automatic do_clear();
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b1;
        @(negedge clk);
        clear    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] fa, fb, nxt, am;

        fib_tab[0] = mk(8'd0,  1'b0, 1'b0, 8'd0,  0, 0);
        fib_tab[1] = mk(8'd1,  1'b1, 1'b0, 8'd1,  0, 0);
        fib_tab[2] = mk(8'd1,  1'b1, 1'b0, 8'd2,  1, 0);
        fib_tab[3] = mk(8'd2,  1'b1, 1'b0, 8'd3,  2, 0);
        fib_tab[4] = mk(8'd3,  1'b1, 1'b0, 8'd5,  3, 0);
        fib_tab[5] = mk(8'd5,  1'b1, 1'b0, 8'd8,  4, 0);
        fib_tab[6] = mk(8'd8,  1'b1, 1'b0, 8'd13, 5, 0);
        fib_tab[7] = mk(8'd13, 1'b1, 1'b0, 8'd21, 6, 0);

        wrap_tab[0] = mk(8'd144, 1'b0, 1'b0, 8'd0,   0, 0);
        wrap_tab[1] = mk(8'd233, 1'b1, 1'b0, 8'd121, 0, 0);
        wrap_tab[2] = mk(8'd121, 1'b1, 1'b0, 8'd98,  1, 0);
        wrap_tab[3] = mk(8'd98,  1'b1, 1'b0, 8'd219, 2, 0);

        mis_tab[0] = mk(8'd0,  1'b0, 1'b0, 8'd0,  0, 0);
        mis_tab[1] = mk(8'd1,  1'b1, 1'b0, 8'd1,  0, 0);
        mis_tab[2] = mk(8'd1,  1'b1, 1'b0, 8'd2,  1, 0);
        mis_tab[3] = mk(8'd2,  1'b1, 1'b0, 8'd3,  2, 0);
        mis_tab[4] = mk(8'd4,  1'b0, 1'b1, 8'd0,  2, 1);
        mis_tab[5] = mk(8'd6,  1'b1, 1'b0, 8'd10, 2, 1);
        mis_tab[6] = mk(8'd10, 1'b1, 1'b0, 8'd16, 3, 1);

        rst      = 1'b1;
        in_valid = 1'b0;
        clear    = 1'b0;
        in_data  = 8'd0;

        // reset values while rst is held
        #12;
        chk("reset locked",      {31'd0, locked},      32'd0);
        chk("reset err",         {31'd0, err},         32'd0);
        chk("reset expected",    {24'd0, expected},    32'd0);
        chk("reset match_count", {29'd0, match_count}, 32'd0);
        chk("reset err_count",   {29'd0, err_count},   32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post-reset in_ready", {31'd0, in_ready}, 32'd1);

        // back-to-back Fibonacci stream
        for (int i = 0; i < 8; i++) send(fib_tab[i], 0, "fib");

        // modular wrap
        do_clear();
        for (int i = 0; i < 4; i++) send(wrap_tab[i], 0, "wrap");

        // mismatch, one-cycle resync, relock on the rejected word
        do_clear();
        for (int i = 0; i < 5; i++) send(mis_tab[i], 0, "mis");
        @(negedge clk);
        #1;
        chk("resync in_ready", {31'd0, in_ready}, 32'd0);
        chk("resync err",      {31'd0, err},      32'd1);
        chk("resync locked",   {31'd0, locked},   32'd0);
        @(posedge clk);
        #1;
        chk("err pulse width", {31'd0, err},      32'd0);
        chk("seed1 in_ready",  {31'd0, in_ready}, 32'd1);
        for (int i = 5; i < 7; i++) send(mis_tab[i], 0, "relock");

        // same stream with random gaps
        do_clear();
        for (int i = 0; i < 4; i++) send(fib_tab[i], $urandom_range(0, 5), "gap");

        // clear has priority over an accept
        do_clear();
        for (int i = 0; i < 5; i++) send(fib_tab[i], 0, "pre-clear");
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'd5;
        clear    = 1'b1;
        #1;
        chk("clear in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("clear locked",      {31'd0, locked},      32'd0);
        chk("clear match_count", {29'd0, match_count}, 32'd0);
        chk("clear err_count",   {29'd0, err_count},   32'd0);
        chk("clear expected",    {24'd0, expected},    32'd0);
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        // had 5 been consumed as a seed, 7 would lock with expected 12
        send(mk(8'd7, 1'b0, 1'b0, 8'd0,  0, 0), 0, "after-clear");
        send(mk(8'd8, 1'b1, 1'b0, 8'd15, 0, 0), 0, "after-clear");

        // asynchronous reset between edges
        do_clear();
        for (int i = 0; i < 3; i++) send(fib_tab[i], 0, "pre-rst");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst locked",      {31'd0, locked},      32'd0);
        chk("async rst match_count", {29'd0, match_count}, 32'd0);
        chk("async rst expected",    {24'd0, expected},    32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) send(fib_tab[i], 0, "post-rst");

        // match_count saturation
        do_clear();
        send(mk(8'd0, 1'b0, 1'b0, 8'd0, 0, 0), 0, "msat seed");
        send(mk(8'd1, 1'b1, 1'b0, 8'd1, 0, 0), 0, "msat seed");
        fa = 8'd0;
        fb = 8'd1;
        for (int i = 0; i < 9; i++) begin
            nxt = fa + fb;
            send(mk(nxt, 1'b1, 1'b0, 8'(fb + nxt), (i + 1 > 7) ? 7 : i + 1, 0), 0, "msat");
            fa = fb;
            fb = nxt;
        end

        // err_count saturation
        do_clear();
        send(mk(8'd3, 1'b0, 1'b0, 8'd0, 0, 0), 0, "esat seed");
        am = 8'd3;
        for (int i = 1; i <= 9; i++) begin
            send(mk(8'd0, 1'b1, 1'b0, am, 0, (i - 1 > 7) ? 7 : i - 1), 0, "esat lock");
            send(mk(8'(am + 8'd1), 1'b0, 1'b1, 8'd0, 0, (i > 7) ? 7 : i), 0, "esat err");
            am = am + 8'd1;
        end

        @(negedge clk);
        in_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
